// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes plus operation and response records.
// Used by decode, the alu and the alu_arbiter.
package alu_pkg;

  localparam int ALU_W  = 32;
  localparam int ALU_FW = 5;

  typedef enum logic [ALU_FW-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10
  } alu_fn_e;

  typedef struct packed {
    logic [ALU_FW-1:0] f;
    logic [ALU_W-1:0]  a;
    logic [ALU_W-1:0]  b;
  } alu_op_t;

  typedef struct packed {
    logic             id;
    logic [ALU_W-1:0] y;
    logic             zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two requester valid/ready channels plus the registered response channel.
// The requester/consumer side holds the master modport, the arbiter the slave modport.
interface alu_arbiter_if
  import alu_pkg::*;
  #(parameter int W = ALU_W, parameter int FW = ALU_FW);

  logic          req0_valid;
  logic          req0_ready;
  logic [FW-1:0] req0_f;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;

  logic          req1_valid;
  logic          req1_ready;
  logic [FW-1:0] req1_f;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_y;
  logic          rsp_zero;

  modport master (
    output req0_valid, req0_f, req0_a, req0_b,
    output req1_valid, req1_f, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_f, req0_a, req0_b,
    input  req1_valid, req1_f, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_zero
  );

endinterface

// File: rtl/alu.sv
// Existing combinational ALU: Y = F(A, B), Zero flags an all-zero Y.
module alu
  import alu_pkg::*;
  #(parameter int W = ALU_W, parameter int FW = ALU_FW)
  (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [FW-1:0] f,
    output logic [W-1:0]  y,
    output logic          zero
  );

  localparam int SH = $clog2(W);

  always_comb begin
    y = '0;
    case (f)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(W-1){1'b0}}, (a < b)};
      ALU_SLL:  y = a << b[SH-1:0];
      ALU_SRL:  y = a >> b[SH-1:0];
      ALU_SRA:  y = $signed(a) >>> b[SH-1:0];
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way grant with a one-bit round-robin pointer; RR=0 degrades to fixed req0 priority.
// The pointer only moves on an accepted grant, never on a stalled one.
module rr_arb2 #(parameter bit RR = 1'b1)
  (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       gnt_id
  );

  logic ptr;

  always_comb begin
    grant  = 2'b00;
    gnt_id = 1'b0;
    case (valid)
      2'b01: begin
        grant  = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        grant  = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        if (RR && ptr) begin
          grant  = 2'b10;
          gnt_id = 1'b1;
        end else begin
          grant  = 2'b01;
          gnt_id = 1'b0;
        end
      end
      default: begin
        grant  = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between the issue pipe (req0) and the branch/address unit (req1),
// registering each result with its requester id in a one-entry output stage.
//
// state    | meaning
// ST_EMPTY | no result held, rsp_valid=0, any grant is accepted
// ST_FULL  | result held, rsp_valid=1, new accept only when rsp_ready
module alu_arbiter
  import alu_pkg::*;
  #(parameter int W = ALU_W, parameter int FW = ALU_FW, parameter bit RR = 1'b1)
  (
    input  logic          clk,
    input  logic          rstn,
    alu_arbiter_if.slave  bus
  );

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state;
  logic          can_accept;
  logic          accept;
  logic [1:0]    grant;
  logic          gnt_id;
  logic [FW-1:0] alu_f;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_y;
  logic          alu_zero;
  logic          rsp_id_q;
  logic [W-1:0]  rsp_y_q;
  logic          rsp_zero_q;

  rr_arb2 #(.RR(RR)) u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  // rstn gates ready so nothing is accepted while reset is held
  assign can_accept     = (state == ST_EMPTY) || bus.rsp_ready;
  assign bus.req0_ready = rstn && grant[0] && can_accept;
  assign bus.req1_ready = rstn && grant[1] && can_accept;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    alu_f = bus.req0_f;
    alu_a = bus.req0_a;
    alu_b = bus.req0_b;
    if (gnt_id) begin
      alu_f = bus.req1_f;
      alu_a = bus.req1_a;
      alu_b = bus.req1_b;
    end
  end

  alu #(.W(W), .FW(FW)) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .f    (alu_f),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_EMPTY;
      rsp_id_q   <= 1'b0;
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b0;
    end else if (accept) begin
      state      <= ST_FULL;
      rsp_id_q   <= gnt_id;
      rsp_y_q    <= alu_y;
      rsp_zero_q <= alu_zero;
    end else if (bus.rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign bus.rsp_valid = (state == ST_FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a reference model per instance queues expected results and checks every cycle.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = ALU_W;

  typedef struct packed {
    logic         id;
    logic [W-1:0] y;
    logic         zero;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W), .FW(ALU_FW)) bus_rr ();
  alu_arbiter_if #(.W(W), .FW(ALU_FW)) bus_fp ();

  alu_arbiter #(.W(W), .FW(ALU_FW), .RR(1'b1)) u_rr (.clk(clk), .rstn(rstn), .bus(bus_rr));
  alu_arbiter #(.W(W), .FW(ALU_FW), .RR(1'b0)) u_fp (.clk(clk), .rstn(rstn), .bus(bus_fp));

  int   n_vec  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;
  exp_t q_rr[$];
  exp_t q_fp[$];
  logic ptr_rr = 1'b0;
  logic ptr_fp = 1'b0;

  function automatic logic [W-1:0] ref_y(input logic [4:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] ext;
    logic [W-1:0]   r;
    r = '0;
    case (f)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a + ~b + 32'd1;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~a & ~b;
      ALU_SLT:  r = (a[W-1] != b[W-1]) ? {31'd0, a[W-1]} : {31'd0, (a < b)};
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA: begin
        ext = {{W{a[W-1]}}, a} >> b[4:0];
        r   = ext[W-1:0];
      end
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ref_grant(input logic v0, input logic v1, input logic rr,
                                           input logic ptr);
    if (v0 && v1) return (rr && ptr) ? 2'b10 : 2'b01;
    return {v1, v0};
  endfunction

  task automatic drive(input logic v0, input logic [4:0] f0, input logic [W-1:0] a0,
                       input logic [W-1:0] b0, input logic v1, input logic [4:0] f1,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr);
    bus_rr.req0_valid = v0; bus_rr.req0_f = f0; bus_rr.req0_a = a0; bus_rr.req0_b = b0;
    bus_rr.req1_valid = v1; bus_rr.req1_f = f1; bus_rr.req1_a = a1; bus_rr.req1_b = b1;
    bus_rr.rsp_ready  = rr;
    bus_fp.req0_valid = v0; bus_fp.req0_f = f0; bus_fp.req0_a = a0; bus_fp.req0_b = b0;
    bus_fp.req1_valid = v1; bus_fp.req1_f = f1; bus_fp.req1_a = a1; bus_fp.req1_b = b1;
    bus_fp.rsp_ready  = rr;
  endtask

  task automatic idle();
    drive(1'b0, ALU_ADD, '0, '0, 1'b0, ALU_ADD, '0, '0, 1'b1);
  endtask

  // Reference model for the round-robin instance; inputs change only on negedges.
  always begin : mon_rr
    logic [1:0]   g;
    logic         full, can, e0, e1;
    logic [W-1:0] yv;
    exp_t         e;
    @(negedge clk);
    #2;
    if (!rstn || !mon_en) begin
      q_rr.delete();
      ptr_rr = 1'b0;
    end else begin
      g    = ref_grant(bus_rr.req0_valid, bus_rr.req1_valid, 1'b1, ptr_rr);
      full = (q_rr.size() != 0);
      can  = !full || bus_rr.rsp_ready;
      e0   = g[0] && can;
      e1   = g[1] && can;
      n_vec++;
      if ({bus_rr.req1_ready, bus_rr.req0_ready} !== {e1, e0}) begin
        n_err++;
        $display("FAIL mon_rr_ready got %b%b want %b%b", bus_rr.req1_ready, bus_rr.req0_ready, e1, e0);
      end
      n_vec++;
      if (bus_rr.rsp_valid !== full) begin
        n_err++;
        $display("FAIL mon_rr_valid got %b want %b", bus_rr.rsp_valid, full);
      end
      if (full) begin
        n_vec++;
        if ({bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero} !== q_rr[0]) begin
          n_err++;
          $display("FAIL mon_rr_rsp got id=%b y=%h z=%b want id=%b y=%h z=%b",
                   bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero, q_rr[0].id, q_rr[0].y, q_rr[0].zero);
        end
        if (bus_rr.rsp_ready) void'(q_rr.pop_front());
      end
      if (e0 || e1) begin
        yv     = e1 ? ref_y(bus_rr.req1_f, bus_rr.req1_a, bus_rr.req1_b)
                    : ref_y(bus_rr.req0_f, bus_rr.req0_a, bus_rr.req0_b);
        e.id   = e1;
        e.y    = yv;
        e.zero = (yv == '0);
        q_rr.push_back(e);
        ptr_rr = ~e1;
      end
    end
  end

  always begin : mon_fp
    logic [1:0]   g;
    logic         full, can, e0, e1;
    logic [W-1:0] yv;
    exp_t         e;
    @(negedge clk);
    #2;
    if (!rstn || !mon_en) begin
      q_fp.delete();
      ptr_fp = 1'b0;
    end else begin
      g    = ref_grant(bus_fp.req0_valid, bus_fp.req1_valid, 1'b0, ptr_fp);
      full = (q_fp.size() != 0);
      can  = !full || bus_fp.rsp_ready;
      e0   = g[0] && can;
      e1   = g[1] && can;
      n_vec++;
      if ({bus_fp.req1_ready, bus_fp.req0_ready} !== {e1, e0}) begin
        n_err++;
        $display("FAIL mon_fp_ready got %b%b want %b%b", bus_fp.req1_ready, bus_fp.req0_ready, e1, e0);
      end
      n_vec++;
      if (bus_fp.rsp_valid !== full) begin
        n_err++;
        $display("FAIL mon_fp_valid got %b want %b", bus_fp.rsp_valid, full);
      end
      if (full) begin
        n_vec++;
        if ({bus_fp.rsp_id, bus_fp.rsp_y, bus_fp.rsp_zero} !== q_fp[0]) begin
          n_err++;
          $display("FAIL mon_fp_rsp got id=%b y=%h z=%b want id=%b y=%h z=%b",
                   bus_fp.rsp_id, bus_fp.rsp_y, bus_fp.rsp_zero, q_fp[0].id, q_fp[0].y, q_fp[0].zero);
        end
        if (bus_fp.rsp_ready) void'(q_fp.pop_front());
      end
      if (e0 || e1) begin
        yv     = e1 ? ref_y(bus_fp.req1_f, bus_fp.req1_a, bus_fp.req1_b)
                    : ref_y(bus_fp.req0_f, bus_fp.req0_a, bus_fp.req0_b);
        e.id   = e1;
        e.y    = yv;
        e.zero = (yv == '0);
        q_fp.push_back(e);
        ptr_fp = ~e1;
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b1, ALU_SUB, 32'd9, 32'd4, 1'b1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({bus_rr.req1_ready, bus_rr.req0_ready, bus_fp.req1_ready, bus_fp.req0_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ready got %b%b%b%b want 0000", bus_rr.req1_ready, bus_rr.req0_ready,
               bus_fp.req1_ready, bus_fp.req0_ready);
    end
    n_vec++;
    if ({bus_rr.rsp_valid, bus_fp.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_valid got %b%b want 00", bus_rr.rsp_valid, bus_fp.rsp_valid);
    end
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    #1;
    n_vec++;
    if ({bus_rr.req1_ready, bus_rr.req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_first_grant got %b%b want 01", bus_rr.req1_ready, bus_rr.req0_ready);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y} !== {1'b1, 1'b0, 32'd3}) begin
      n_err++;
      $display("FAIL reset_first_rsp got v=%b id=%b y=%h want v=1 id=0 y=3",
               bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async_rr got v=%b id=%b y=%h z=%b want all 0",
               bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero);
    end
    n_vec++;
    if ({bus_fp.rsp_valid, bus_fp.rsp_y} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_async_fp got v=%b y=%h want v=0 y=0", bus_fp.rsp_valid, bus_fp.rsp_y);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    drive(1'b1, ALU_ADD, 32'h0000_0005, 32'h0000_0003, 1'b0, ALU_ADD, '0, '0, 1'b1);
    #1;
    n_vec++;
    if ({bus_rr.req0_ready, bus_fp.req0_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL add_ready got %b%b want 11", bus_rr.req0_ready, bus_fp.req0_ready);
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if ({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero} !== {1'b1, 1'b0, 32'h8, 1'b0}) begin
      n_err++;
      $display("FAIL add_rsp_rr got v=%b id=%b y=%h z=%b want v=1 id=0 y=8 z=0",
               bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero);
    end
    n_vec++;
    if ({bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_y, bus_fp.rsp_zero} !== {1'b1, 1'b0, 32'h8, 1'b0}) begin
      n_err++;
      $display("FAIL add_rsp_fp got v=%b id=%b y=%h z=%b want v=1 id=0 y=8 z=0",
               bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_y, bus_fp.rsp_zero);
    end
  endtask

  task automatic test_round_robin();
    int   c0 = 0;
    int   c1 = 0;
    logic exp_g = 1'b1;   // the single req0 accept before this left the pointer at req1
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive(1'b1, ALU_ADD, i, 32'd1, 1'b1, ALU_XOR, i, 32'hFF, 1'b1);
      #1;
      if (i > 0) begin
        n_vec++;
        if ({bus_rr.rsp_valid, bus_rr.rsp_id} !== {1'b1, ~exp_g}) begin
          n_err++;
          $display("FAIL rr_id cycle %0d got v=%b id=%b want v=1 id=%b", i, bus_rr.rsp_valid,
                   bus_rr.rsp_id, ~exp_g);
        end
      end
      n_vec++;
      if ({bus_rr.req1_ready, bus_rr.req0_ready} !== {exp_g, ~exp_g}) begin
        n_err++;
        $display("FAIL rr_grant cycle %0d got %b%b want %b%b", i, bus_rr.req1_ready,
                 bus_rr.req0_ready, exp_g, ~exp_g);
      end
      c0 += int'(bus_rr.req0_ready);
      c1 += int'(bus_rr.req1_ready);
      exp_g = ~exp_g;
    end
    n_vec++;
    if (c0 != 50 || c1 != 50) begin
      n_err++;
      $display("FAIL rr_counts got req0=%0d req1=%0d want 50/50", c0, c1);
    end
  endtask

  task automatic test_sub_zero();
    @(negedge clk);
    drive(1'b0, ALU_ADD, '0, '0, 1'b1, ALU_SUB, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    #1;
    n_vec++;
    if ({bus_rr.req1_ready, bus_fp.req1_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL sub_ready got %b%b want 11", bus_rr.req1_ready, bus_fp.req1_ready);
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if ({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL sub_rsp_rr got v=%b id=%b y=%h z=%b want v=1 id=1 y=0 z=1",
               bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y, bus_rr.rsp_zero);
    end
    n_vec++;
    if ({bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_y, bus_fp.rsp_zero} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL sub_rsp_fp got v=%b id=%b y=%h z=%b want v=1 id=1 y=0 z=1",
               bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_y, bus_fp.rsp_zero);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    idle();
    @(negedge clk);
    drive(1'b1, ALU_OR, 32'hF0, 32'h0F, 1'b0, ALU_ADD, '0, '0, 1'b0);
    #1;
    n_vec++;
    if (bus_rr.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_fill got %b want 1", bus_rr.req0_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, ALU_OR, 32'hF0, 32'h0F, 1'b1, ALU_AND, 32'hFF00, 32'h0FF0, 1'b0);
      #1;
      n_vec++;
      if ({bus_rr.req1_ready, bus_rr.req0_ready, bus_fp.req1_ready, bus_fp.req0_ready} !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_ready stall %0d got %b%b%b%b want 0000", i, bus_rr.req1_ready,
                 bus_rr.req0_ready, bus_fp.req1_ready, bus_fp.req0_ready);
      end
      n_vec++;
      if ({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y} !== {1'b1, 1'b0, 32'hFF}) begin
        n_err++;
        $display("FAIL bp_hold stall %0d got v=%b id=%b y=%h want v=1 id=0 y=ff", i,
                 bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y);
      end
    end
    @(negedge clk);
    drive(1'b1, ALU_OR, 32'hF0, 32'h0F, 1'b1, ALU_AND, 32'hFF00, 32'h0FF0, 1'b1);
    #1;
    n_vec++;
    if ({bus_rr.req1_ready, bus_rr.req0_ready, bus_fp.req1_ready, bus_fp.req0_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL bp_release got %b%b%b%b want 1001", bus_rr.req1_ready, bus_rr.req0_ready,
               bus_fp.req1_ready, bus_fp.req0_ready);
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if ({bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y} !== {1'b1, 1'b1, 32'h0F00}) begin
      n_err++;
      $display("FAIL bp_next_rsp got v=%b id=%b y=%h want v=1 id=1 y=f00",
               bus_rr.rsp_valid, bus_rr.rsp_id, bus_rr.rsp_y);
    end
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, ALU_ADD, i, 32'd2, 1'b1, ALU_SUB, i, 32'd1, 1'b1);
      #1;
      n_vec++;
      if ({bus_fp.req1_ready, bus_fp.req0_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL fp_grant cycle %0d got %b%b want 01", i, bus_fp.req1_ready, bus_fp.req0_ready);
      end
    end
    @(negedge clk);
    drive(1'b0, ALU_ADD, '0, '0, 1'b1, ALU_SUB, 32'd7, 32'd7, 1'b1);
    #1;
    n_vec++;
    if ({bus_fp.req1_ready, bus_fp.req0_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL fp_req1_alone got %b%b want 10", bus_fp.req1_ready, bus_fp.req0_ready);
    end
    @(negedge clk);
    idle();
    #1;
    n_vec++;
    if ({bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_zero} !== 3'b111) begin
      n_err++;
      $display("FAIL fp_req1_rsp got v=%b id=%b z=%b want 1 1 1", bus_fp.rsp_valid, bus_fp.rsp_id,
               bus_fp.rsp_zero);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a0, b0, a1, b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a0 = $urandom();
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom();
      a1 = $urandom_range(0, 3);
      b1 = ($urandom_range(0, 1) == 0) ? a1 : $urandom();
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 12)), a0, b0,
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 12)), a1, b1,
            ($urandom_range(0, 3) != 0));
    end
    repeat (3) begin
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    #3;
    n_vec++;
    if (q_rr.size() != 0 || q_fp.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain got %0d/%0d pending want 0/0", q_rr.size(), q_fp.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_sub_zero();
    test_backpressure();
    test_fixed_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
